// File: rtl/grid_video_renderer.sv
// grid_video_renderer: composites the Tetris playfield over a tiled 256x256 background, one RGB332 byte per pixel.
// Optional feature: define GRID_LINES_EN to draw grey (8'h49) lines on the first pixel row/column of each cell.
module grid_video_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int PF_X0    = 200,
    parameter int CELL     = 24,
    parameter int COLS     = 10,
    parameter int ROWS     = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        px_en,
    input  logic [7:0]  vga_data,
    input  logic [7:0]  grid_data,
    output logic [7:0]  pixel_rgb,
    output logic [7:0]  grid_addr,
    output logic [15:0] vga_addr
);
    localparam int PF_X1 = PF_X0 + CELL * COLS;
    logic [9:0] x;
    logic [8:0] y;
    logic       phase, px_en_q;
    logic [4:0] cx, cy, row;
    logic [3:0] col;
    logic       pf_q, act_q, gl_q;
    logic       in_pf, cell_adv, grid_line;
    logic [7:0] comp;
    // Pixel classification for the issued pixel and composite of the pixel whose RAM data is now valid
    always_comb begin
        in_pf    = x >= 10'(PF_X0) && x < 10'(PF_X1) && y < 9'(V_ACTIVE);
        cell_adv = x >= 10'(PF_X0) && x < 10'(PF_X1 - 1);
`ifdef GRID_LINES_EN
        grid_line = in_pf && (cx == 5'd0 || cy == 5'd0);
`else
        grid_line = 1'b0;
`endif
        comp = gl_q ? 8'h49 : (pf_q && grid_data != 8'h00) ? grid_data : act_q ? vga_data : 8'h00;
    end
    // Raster walk: phase 0 issues addresses and emits the previous pixel, phase 1 advances x; line end on px_en fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            phase     <= 1'b0;
            px_en_q   <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            col       <= '0;
            row       <= '0;
            pf_q      <= 1'b0;
            act_q     <= 1'b0;
            gl_q      <= 1'b0;
            pixel_rgb <= '0;
            grid_addr <= '0;
            vga_addr  <= '0;
        end else begin
            px_en_q <= px_en;
            if (!px_en) begin
                phase     <= 1'b0;
                pixel_rgb <= '0;
                pf_q      <= 1'b0;
                act_q     <= 1'b0;
                gl_q      <= 1'b0;
                if (px_en_q) begin
                    x   <= '0;
                    cx  <= '0;
                    col <= '0;
                    y   <= y == 9'(V_ACTIVE - 1) ? 9'd0 : y + 9'd1;
                    cy  <= (cy == 5'(CELL - 1) || y == 9'(V_ACTIVE - 1)) ? 5'd0 : cy + 5'd1;
                    row <= y == 9'(V_ACTIVE - 1) ? 5'd0 :
                           cy == 5'(CELL - 1) ? (row == 5'(ROWS - 1) ? 5'd0 : row + 5'd1) : row;
                end
            end else if (!phase) begin
                phase     <= 1'b1;
                vga_addr  <= {y[7:0], x[7:0]};
                grid_addr <= 8'(row) * 8'(COLS) + 8'(col);
                pf_q      <= in_pf;
                act_q     <= x < 10'(H_ACTIVE) && y < 9'(V_ACTIVE);
                gl_q      <= grid_line;
                pixel_rgb <= comp;
            end else begin
                phase <= 1'b0;
                if (x != 10'(H_ACTIVE)) begin
                    x   <= x + 10'd1;
                    cx  <= cell_adv ? (cx == 5'(CELL - 1) ? 5'd0 : cx + 5'd1) : 5'd0;
                    col <= cell_adv ? (cx == 5'(CELL - 1) ? col + 4'd1 : col) : 4'd0;
                end
            end
        end
    end
endmodule

// File: tb/tb_grid_video_renderer.sv
// tb_grid_video_renderer: directed raster tests with RAM models and an arithmetic (divide-based) pixel model.
module tb_grid_video_renderer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        px_en = 1'b0;
    logic [7:0]  vga_data = 8'h00;
    logic [7:0]  grid_data = 8'h00;
    logic [7:0]  pixel_rgb;
    logic [7:0]  grid_addr;
    logic [15:0] vga_addr;
    logic [7:0]  grid_mem [0:255];
    bit          vga_fill = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          ly = 0;
    logic [15:0] last_vga = 16'h0000;
    logic [7:0]  last_grid = 8'h00;

    grid_video_renderer dut (
        .clk(clk), .reset(reset), .px_en(px_en), .vga_data(vga_data), .grid_data(grid_data),
        .pixel_rgb(pixel_rgb), .grid_addr(grid_addr), .vga_addr(vga_addr)
    );

    always #10 clk = ~clk;

    // Synchronous-read RAM models
    always @(posedge clk) begin
        grid_data <= grid_mem[grid_addr];
        vga_data  <= vga_fill ? (vga_addr[7:0] ^ vga_addr[15:8] ^ 8'h5A) : 8'h00;
    end

    function automatic int exp_grid(input int px, input int py);
        return (px >= 200 && px < 440) ? (py / 24) * 10 + (px - 200) / 24 : (py / 24) * 10;
    endfunction

    function automatic logic [7:0] exp_pix(input int px, input int py);
        int a;
        if (px >= 640) return 8'h00;
        if (px >= 200 && px < 440) begin
`ifdef GRID_LINES_EN
            if ((px - 200) % 24 == 0 || py % 24 == 0) return 8'h49;
`endif
            a = (py / 24) * 10 + (px - 200) / 24;
            if (grid_mem[a] != 8'h00) return grid_mem[a];
        end
        return vga_fill ? (8'(px) ^ 8'(py) ^ 8'h5A) : 8'h00;
    endfunction

    task automatic drive_line(input int n);
        int xi, xp;
        logic [7:0] ep;
        px_en = 1'b1;
        for (int e = 0; e < n; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e % 2 == 0) begin
                xi = (e / 2 > 640) ? 640 : e / 2;
                last_vga = {8'(ly), 8'(xi)};
                last_grid = 8'(exp_grid(xi, ly));
                checks++;
                if (vga_addr !== last_vga) begin
                    failures++;
                    $display("FAIL vga_addr y=%0d x=%0d got=%h exp=%h", ly, xi, vga_addr, last_vga);
                end
                checks++;
                if (grid_addr !== last_grid) begin
                    failures++;
                    $display("FAIL grid_addr y=%0d x=%0d got=%0d exp=%0d", ly, xi, grid_addr, last_grid);
                end
            end
            xp = (e < 2) ? -1 : (e - 2 - e % 2) / 2;
            if (xp > 640) xp = 640;
            ep = (xp < 0) ? 8'h00 : exp_pix(xp, ly);
            checks++;
            if (pixel_rgb !== ep) begin
                failures++;
                $display("FAIL pixel y=%0d x=%0d edge=%0d got=%h exp=%h", ly, xp, e, pixel_rgb, ep);
            end
        end
    endtask

    task automatic end_line(input int gap);
        px_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pixel_rgb !== 8'h00) begin
            failures++;
            $display("FAIL gap_pixel y=%0d got=%h exp=00", ly, pixel_rgb);
        end
        checks++;
        if (vga_addr !== last_vga || grid_addr !== last_grid) begin
            failures++;
            $display("FAIL gap_addr_hold y=%0d got=%h/%0d exp=%h/%0d", ly, vga_addr, grid_addr, last_vga, last_grid);
        end
        ly = (ly + 1) % 480;
        repeat (gap - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (pixel_rgb !== 8'h00) begin
            failures++;
            $display("FAIL gap_end_pixel got=%h exp=00", pixel_rgb);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pixel_rgb !== 8'h00 || grid_addr !== 8'h00 || vga_addr !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state got=%h/%0d/%h exp=00/0/0000", pixel_rgb, grid_addr, vga_addr);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (pixel_rgb !== 8'h00 || grid_addr !== 8'h00 || vga_addr !== 16'h0000) begin
            failures++;
            $display("FAIL idle_after_reset got=%h/%0d/%h exp=00/0/0000", pixel_rgb, grid_addr, vga_addr);
        end
    endtask

    task automatic test_background_line();
        vga_fill = 1'b0;
        drive_line(1270);
        end_line(15);
    endtask

    task automatic test_line_sequencing();
        vga_fill = 1'b1;
        repeat (3) @(negedge clk);
        for (int l = 1; l < 25; l++) begin
            drive_line(1270);
            end_line(15);
        end
    endtask

    task automatic test_saturation();
        drive_line(1300);
        checks++;
        if (vga_addr !== {8'(ly), 8'h80}) begin
            failures++;
            $display("FAIL x_saturate got=%h exp=%h", vga_addr, {8'(ly), 8'h80});
        end
        end_line(15);
    endtask

    task automatic test_reset_midline();
        drive_line(101);
        reset = 1'b1;
        px_en = 1'b0;
        #1;
        checks++;
        if (pixel_rgb !== 8'h00 || grid_addr !== 8'h00 || vga_addr !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset got=%h/%0d/%h exp=00/0/0000", pixel_rgb, grid_addr, vga_addr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ly = 0;
        repeat (3) @(negedge clk);
        drive_line(1270);
        end_line(15);
    endtask

    task automatic test_frame_wrap();
        while (ly != 0) begin
            drive_line(6);
            end_line(3);
        end
        drive_line(2);
        checks++;
        if (vga_addr !== 16'h0000 || grid_addr !== 8'h00) begin
            failures++;
            $display("FAIL frame_wrap got=%h/%0d exp=0000/0", vga_addr, grid_addr);
        end
        end_line(3);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) grid_mem[i] = 8'h00;
        grid_mem[1]  = 8'h01;
        grid_mem[10] = 8'hE0;
        grid_mem[25] = 8'h1C;
        test_reset();
        test_background_line();
        test_line_sequencing();
        test_saturation();
        test_reset_midline();
        test_frame_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
